// File: rtl/id_ex_operand_if.sv
// ----------------------------------------------------------------------------
// id_ex_operand_if
// Bundles the ID-stage read request, the WB write port, the EX-aligned forward
// selects/data and the EX operand outputs of id_ex_operand.
//   slave  : the operand block (consumes ID/WB/forward, drives EX outputs)
//   master : the surrounding pipeline (drives ID/WB/forward, consumes EX)
// ----------------------------------------------------------------------------
interface id_ex_operand_if;
   logic        id_valid;
   logic [4:0]  rs_rf_raddr;
   logic [4:0]  rt_rf_raddr;
   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic        sel_rs_forward_r;
   logic        sel_rt_forward_r;
   logic [31:0] rs_forward_data_r;
   logic [31:0] rt_forward_data_r;
   logic        ex_valid;
   logic [4:0]  ex_rs_addr;
   logic [4:0]  ex_rt_addr;
   logic [31:0] ex_rs_val;
   logic [31:0] ex_rt_val;

   modport master (
      output id_valid, rs_rf_raddr, rt_rf_raddr,
      output wb_we, wb_waddr, wb_wdata,
      output sel_rs_forward_r, sel_rt_forward_r,
      output rs_forward_data_r, rt_forward_data_r,
      input  ex_valid, ex_rs_addr, ex_rt_addr, ex_rs_val, ex_rt_val
   );

   modport slave (
      input  id_valid, rs_rf_raddr, rt_rf_raddr,
      input  wb_we, wb_waddr, wb_wdata,
      input  sel_rs_forward_r, sel_rt_forward_r,
      input  rs_forward_data_r, rt_forward_data_r,
      output ex_valid, ex_rs_addr, ex_rt_addr, ex_rs_val, ex_rt_val
   );
endinterface

// File: rtl/id_ex_operand.sv
// ----------------------------------------------------------------------------
// id_ex_operand
// 32x32 register file read in ID (with WB write-through), the ID/EX pipeline
// register for valid/source numbers/operands, and the EX operand muxes that
// apply the registered forwarding selects.
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset (clears register file and ID/EX)
//   stall : stall bus; bit 2 = ID stage, bit 3 = EX stage, 1 = stop
//   flush : kills the ID/EX contents at the next edge
//   bus   : id_ex_operand_if.slave (ID read, WB write, forward, EX outputs)
// ----------------------------------------------------------------------------
module id_ex_operand (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [5:0]            stall,
   input  logic                  flush,
   id_ex_operand_if.slave        bus
);

   logic [31:0] rf [32];
   logic [31:0] rs_rd, rt_rd;

   logic        idex_valid;
   logic [4:0]  idex_rs_addr, idex_rt_addr;
   logic [31:0] idex_rs_data, idex_rt_data;

   logic        id_stop, ex_stop;
   logic        wb_hit;
   logic        unused_stall;

   assign id_stop      = stall[2];
   assign ex_stop      = stall[3];
   assign unused_stall = ^{stall[5:4], stall[1:0]};
   assign wb_hit       = bus.wb_we && (bus.wb_waddr != 5'd0);

   // Register file; WB writes land regardless of stall/flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
      end else if (wb_hit) begin
         rf[bus.wb_waddr] <= bus.wb_wdata;
      end
   end

   // ID read ports with same-cycle WB write-through; $0 always reads zero.
   always_comb begin
      rs_rd = rf[bus.rs_rf_raddr];
      rt_rd = rf[bus.rt_rf_raddr];
      if (wb_hit && (bus.wb_waddr == bus.rs_rf_raddr)) rs_rd = bus.wb_wdata;
      if (wb_hit && (bus.wb_waddr == bus.rt_rf_raddr)) rt_rd = bus.wb_wdata;
      if (bus.rs_rf_raddr == 5'd0) rs_rd = '0;
      if (bus.rt_rf_raddr == 5'd0) rt_rd = '0;
   end

   // ID/EX register: flush > bubble (ID stop, EX go) > load (ID go) > hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idex_valid   <= 1'b0;
         idex_rs_addr <= '0;
         idex_rt_addr <= '0;
         idex_rs_data <= '0;
         idex_rt_data <= '0;
      end else if (flush || (id_stop && !ex_stop)) begin
         idex_valid   <= 1'b0;
         idex_rs_addr <= '0;
         idex_rt_addr <= '0;
         idex_rs_data <= '0;
         idex_rt_data <= '0;
      end else if (!id_stop) begin
         idex_valid   <= bus.id_valid;
         idex_rs_addr <= bus.rs_rf_raddr;
         idex_rt_addr <= bus.rt_rf_raddr;
         idex_rs_data <= rs_rd;
         idex_rt_data <= rt_rd;
      end
   end

   assign bus.ex_valid   = idex_valid;
   assign bus.ex_rs_addr = idex_rs_addr;
   assign bus.ex_rt_addr = idex_rt_addr;

   // Latched source $0 forces a zero operand over forwarding. While reset is
   // held the forward path stays visible (latched data is zero anyway), so
   // the $0 override only applies out of reset.
   always_comb begin
      bus.ex_rs_val = bus.sel_rs_forward_r ? bus.rs_forward_data_r : idex_rs_data;
      bus.ex_rt_val = bus.sel_rt_forward_r ? bus.rt_forward_data_r : idex_rt_data;
      if (rst && (idex_rs_addr == 5'd0)) bus.ex_rs_val = '0;
      if (rst && (idex_rt_addr == 5'd0)) bus.ex_rt_val = '0;
   end

endmodule

// File: tb/tb_id_ex_operand.sv
module tb_id_ex_operand;

   logic       clk;
   logic       rst;
   logic [5:0] stall;
   logic       flush;

   id_ex_operand_if bus ();

   id_ex_operand dut (
      .clk   (clk),
      .rst   (rst),
      .stall (stall),
      .flush (flush),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0]  st;
      logic        fl;
      logic        iv;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        srs;
      logic        srt;
      logic [31:0] frs;
      logic [31:0] frt;
      logic        ev;
      logic [4:0]  ea_rs;
      logic [4:0]  ea_rt;
      logic [31:0] ev_rs;
      logic [31:0] ev_rt;
   } vec_t;

   typedef struct packed {
      logic        ev;
      logic [4:0]  ea_rs;
      logic [4:0]  ea_rt;
      logic [31:0] ev_rs;
      logic [31:0] ev_rt;
   } exp_t;

   localparam int NV = 14;
   vec_t vecs [NV];
   exp_t sb [$];

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      stall                 = v.st;
      flush                 = v.fl;
      bus.id_valid          = v.iv;
      bus.rs_rf_raddr       = v.rs;
      bus.rt_rf_raddr       = v.rt;
      bus.wb_we             = v.we;
      bus.wb_waddr          = v.wa;
      bus.wb_wdata          = v.wd;
      bus.sel_rs_forward_r  = v.srs;
      bus.sel_rt_forward_r  = v.srt;
      bus.rs_forward_data_r = v.frs;
      bus.rt_forward_data_r = v.frt;
   endtask

   task automatic compare_ex(input string tag, input exp_t e);
      chk({tag, ".ex_valid"},   {31'd0, bus.ex_valid},   {31'd0, e.ev});
      chk({tag, ".ex_rs_addr"}, {27'd0, bus.ex_rs_addr}, {27'd0, e.ea_rs});
      chk({tag, ".ex_rt_addr"}, {27'd0, bus.ex_rt_addr}, {27'd0, e.ea_rt});
      chk({tag, ".ex_rs_val"},  bus.ex_rs_val,           e.ev_rs);
      chk({tag, ".ex_rt_val"},  bus.ex_rt_val,           e.ev_rt);
   endtask

   initial begin
      exp_t e;
      vec_t idle;
      //            st        fl iv rs    rt    we wa    wd            srs srt frs           frt            ev ers   ert   ex_rs_val     ex_rt_val
      vecs[0]  = '{6'b000000, 0, 0, 5'd0, 5'd0, 1, 5'd5, 32'h1234_5678, 0, 0, 32'h0,         32'h0,         0, 5'd0, 5'd0, 32'h0,         32'h0};
      vecs[1]  = '{6'b000000, 0, 1, 5'd5, 5'd0, 0, 5'd0, 32'h0,         0, 0, 32'h0,         32'h0,         1, 5'd5, 5'd0, 32'h1234_5678, 32'h0};
      vecs[2]  = '{6'b000000, 0, 1, 5'd5, 5'd7, 1, 5'd7, 32'hDEAD_BEEF, 0, 0, 32'h0,         32'h0,         1, 5'd5, 5'd7, 32'h1234_5678, 32'hDEAD_BEEF};
      vecs[3]  = '{6'b000000, 0, 1, 5'd0, 5'd7, 1, 5'd0, 32'hFFFF_FFFF, 1, 0, 32'hAAAA_AAAA, 32'h0,         1, 5'd0, 5'd7, 32'h0,         32'hDEAD_BEEF};
      vecs[4]  = '{6'b000000, 0, 1, 5'd7, 5'd5, 0, 5'd0, 32'h0,         0, 1, 32'h0,         32'hCAFE_F00D, 1, 5'd7, 5'd5, 32'hDEAD_BEEF, 32'hCAFE_F00D};
      vecs[5]  = '{6'b000111, 0, 1, 5'd5, 5'd7, 0, 5'd0, 32'h0,         0, 0, 32'h0,         32'h0,         0, 5'd0, 5'd0, 32'h0,         32'h0};
      vecs[6]  = '{6'b000000, 0, 1, 5'd5, 5'd7, 0, 5'd0, 32'h0,         0, 0, 32'h0,         32'h0,         1, 5'd5, 5'd7, 32'h1234_5678, 32'hDEAD_BEEF};
      vecs[7]  = '{6'b001111, 0, 0, 5'd1, 5'd2, 1, 5'd5, 32'h1111_1111, 0, 0, 32'h0,         32'h0,         1, 5'd5, 5'd7, 32'h1234_5678, 32'hDEAD_BEEF};
      vecs[8]  = '{6'b001111, 0, 0, 5'd1, 5'd2, 0, 5'd0, 32'h0,         0, 0, 32'h0,         32'h0,         1, 5'd5, 5'd7, 32'h1234_5678, 32'hDEAD_BEEF};
      vecs[9]  = '{6'b001111, 0, 0, 5'd1, 5'd2, 0, 5'd0, 32'h0,         0, 0, 32'h0,         32'h0,         1, 5'd5, 5'd7, 32'h1234_5678, 32'hDEAD_BEEF};
      vecs[10] = '{6'b000000, 1, 1, 5'd5, 5'd7, 1, 5'd9, 32'h0000_0099, 0, 0, 32'h0,         32'h0,         0, 5'd0, 5'd0, 32'h0,         32'h0};
      vecs[11] = '{6'b000000, 0, 1, 5'd9, 5'd5, 0, 5'd0, 32'h0,         0, 0, 32'h0,         32'h0,         1, 5'd9, 5'd5, 32'h0000_0099, 32'h1111_1111};
      vecs[12] = '{6'b001011, 0, 1, 5'd3, 5'd0, 1, 5'd3, 32'h0000_0055, 0, 0, 32'h0,         32'h0,         1, 5'd3, 5'd0, 32'h0000_0055, 32'h0};
      vecs[13] = '{6'b001111, 0, 0, 5'd1, 5'd2, 0, 5'd0, 32'h0,         1, 0, 32'h0000_00AB, 32'h0,         1, 5'd3, 5'd0, 32'h0000_00AB, 32'h0};

      idle = '0;
      rst  = 1'b0;
      drive(idle);
      #3;
      e = '0;
      compare_ex("reset", e);

      @(negedge clk);
      rst = 1'b1;

      // Table: drive at negedge, expectation queued, compared 1 ns after the edge.
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         sb.push_back({vecs[i].ev, vecs[i].ea_rs, vecs[i].ea_rt, vecs[i].ev_rs, vecs[i].ev_rt});
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL scoreboard: queue empty at vector %0d", i);
         end else begin
            e = sb.pop_front();
            compare_ex($sformatf("vec%0d", i), e);
         end
      end

      // Asynchronous reset between edges while $3=0x55 is latched in EX.
      @(negedge clk);
      drive(idle);
      stall = 6'b001111;
      #2;
      rst = 1'b0;
      #1;
      e = '0;
      compare_ex("async_rst", e);
      bus.sel_rs_forward_r  = 1'b1;
      bus.rs_forward_data_r = 32'h0000_00AB;
      #1;
      chk("rst_fwd.ex_rs_val", bus.ex_rs_val, 32'h0000_00AB);
      bus.sel_rs_forward_r  = 1'b0;
      bus.rs_forward_data_r = 32'h0;

      // Release mid-hold: next edge holds (stays cleared), then a load of $3 reads 0.
      @(negedge clk);
      rst             = 1'b1;
      bus.id_valid    = 1'b1;
      bus.rs_rf_raddr = 5'd3;
      bus.rt_rf_raddr = 5'd3;
      @(posedge clk);
      #1;
      e = '0;
      compare_ex("rel_hold", e);
      @(negedge clk);
      stall = 6'b000000;
      @(posedge clk);
      #1;
      e = '{ev: 1'b1, ea_rs: 5'd3, ea_rt: 5'd3, ev_rs: 32'h0, ev_rt: 32'h0};
      compare_ex("rel_load", e);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
